key_sched_ctrl: RTL and testbench
=================================

Name: key_sched_ctrl

Overview:
Sequencer that owns the key-expansion datapath. It accepts a full cipher key plus key-size configuration in one handshake. It streams the key words into the expansion engine and captures the emitted round-key stream into a local round-key store. The cipher cores read that store through a registered read port, and `key_valid` tells them when a complete schedule is present.

Parameters:
TIMEOUT, 64, max idle cycles between round keys while collecting before abort
RK_DEPTH, 15, round-key store entries (Nr_max+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_nk  in  2  key size: 00=128, 01=192, 11=256; 10 reserved
key_in  in  256  cipher key; word i = key_in[32*i+:32], w0 first; unused upper words ignored
key_start  in  1  load request, accepted only when key_ready=1
key_ready  out  1  controller idle, can accept key_start
key_valid  out  1  store holds complete schedule for latched key
key_err  out  1  sticky error, cleared by next accepted key_start
nr  out  4  rounds of latched key: 10/12/14
ke_nk  out  2  nk to expansion engine, held stable from START until IDLE
ke_start  out  1  one-cycle start pulse to expansion engine
ke_w_valid  out  1  key word valid
ke_w  out  32  key word
ke_busy  in  1  expansion engine busy
ke_rk_valid  in  1  round key valid
ke_rk_first  in  1  first round key of schedule
ke_rk_last  in  1  last round key of schedule
ke_rk  in  128  round key
rk_rd_en  in  1  store read strobe
rk_rd_addr  in  4  round index
rk_rd_data  out  128  registered read data

Behaviour:
- Reset values: key_ready=1, key_valid=0, key_err=0, nr=0, ke_nk=00, ke_start=0, ke_w_valid=0, ke_w=0, rk_rd_data=0. FSM enters IDLE.
- Reset does not clear store contents; feature below excepted.
- FSM states: IDLE, START, LOAD, COLLECT.
- IDLE:
  - key_start with cfg_nk!=10: latch cfg_nk into ke_nk and the key, set nr (00→10, 01→12, 11→14), clear key_valid and key_err, go START.
  - key_start with cfg_nk=10: set key_err=1, stay IDLE; key_valid unchanged.
- START: ke_start=1 for exactly one cycle, go LOAD.
- LOAD: ke_w_valid=1 every cycle, ke_w=w0..w(Nk-1), word counter 0..Nk-1. Go COLLECT after the last word.
- COLLECT:
  - On ke_rk_valid, write ke_rk to store[wr_ptr] and increment wr_ptr.
  - ke_rk_first forces the write to address 0 and sets wr_ptr=1.
  - Collection starts in LOAD as well; round keys may appear before the last word is sent.
  - On ke_rk_last: if the written count equals nr+1, set key_valid=1; otherwise set key_err=1. Either way go IDLE.
  - A write with wr_ptr>nr is dropped and sets key_err.
  - Idle counter resets on each ke_rk_valid. Reaching TIMEOUT sets key_err and goes IDLE with key_valid=0.
- key_ready=1 only in IDLE. key_start in other states is ignored.
- Read port:
  - rk_rd_data updates the cycle after rk_rd_en with store[rk_rd_addr].
  - Returns 0 when rk_rd_addr>nr or key_valid=0.
  - Holds its value when rk_rd_en=0.
- Write/read to the same address in the same cycle returns old data.
- Reset mid-LOAD or mid-COLLECT: outputs take reset values at once. The expansion engine is expected to be reset on the same rst.

Optional Feature:
KEY_SCHED_ZEROIZE_EN:
- Defined:
  - Adds input key_clear and a ZERO state.
  - key_clear in IDLE, or reset deassertion, enters ZERO: store entries written to 0, one per cycle, RK_DEPTH cycles.
  - During ZERO: key_valid=0, key_ready=0; then return to IDLE.
  - key_clear in other states is deferred until IDLE.
  - key_start arriving during ZERO is ignored.
- Undefined: no key_clear port and no ZERO state; store contents are only overwritten by a new schedule.

Decomposition:
Shared package aes_pkg:
- NK_128/NK_192/NK_256 encodings.
- NR lookup function.
- RK_W=128.
- FSM state typedef.

One sub-module, key_sched_store: RK_DEPTH×128 register file with a write port and a registered read port including the address-range mask. The FSM stays in key_sched_ctrl.

Test Plan:
- AES-128, FIPS-197 A.1 key, w0=0x2b7e1516 → ke_start one cycle, then 4 words, key_valid=1, nr=10, rd addr 10 → d014f9a8 c9ee2589 e13f0cc8 b6630ca6 (words 0..3).
- AES-192, A.2 key, w0=0x8e73b0f7 → 6 words sent, nr=12, rd addr 12 → e98ba06f 448c773c 8ecc7204 01002202.
- AES-256, A.3 key, w0=0x603deb10 → 8 words sent, nr=14, rd addr 14 → fe4890d1 e6188d0b 046df344 706c631e; rd addr 15 → 0.
- cfg_nk=10 with key_start → key_err=1, key_ready stays 1, no ke_start. A following valid start clears key_err.
- Model stalls 64 cycles after 3 round keys → key_err=1 and key_valid=0 at cycle 64; key_start mid-COLLECT is ignored.
- rst pulsed mid-LOAD → all outputs at reset values next edge. Reload AES-128 → correct rk[10]. With KEY_SCHED_ZEROIZE_EN, key_clear → 15 ZERO cycles, then rd addr 0 returns 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared encodings, round-count lookup and FSM state type for the key-schedule sequencer.
// KEY_SCHED_ZEROIZE_EN adds the ZERO state to the state type.
package aes_pkg;

  localparam logic [1:0] NK_128 = 2'b00;
  localparam logic [1:0] NK_192 = 2'b01;
  localparam logic [1:0] NK_256 = 2'b11;

  localparam int RK_W = 128;

`ifdef KEY_SCHED_ZEROIZE_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_COLLECT,
    ST_ZERO
  } ks_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_COLLECT
  } ks_state_t;
`endif

  function automatic logic [3:0] nr_of(input logic [1:0] nk);
    case (nk)
      NK_192:  return 4'd12;
      NK_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [3:0] nk_words(input logic [1:0] nk);
    case (nk)
      NK_128:  return 4'd4;
      NK_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/key_sched_store.sv
// Round-key register file: one write port, registered read port (1-cycle latency) that
// returns 0 for indices beyond rd_max or while rd_allow is low; no backpressure.
module key_sched_store
  import aes_pkg::*;
#(
  parameter int RK_DEPTH = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [RK_W-1:0] wr_data,
  input  logic            rd_en,
  input  logic [3:0]      rd_addr,
  input  logic [3:0]      rd_max,
  input  logic            rd_allow,
  output logic [RK_W-1:0] rd_data
);

  // Contents deliberately survive reset; only a new schedule or a wipe replaces them.
  logic [RK_W-1:0] mem [RK_DEPTH];

  logic rd_in_range;
  assign rd_in_range = rd_allow && (rd_addr <= rd_max) && (32'(rd_addr) < RK_DEPTH);

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < RK_DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// Key-schedule sequencer: latches a key, issues ke_start then Nk words (one per cycle) and collects
// round keys into the store; key_start only taken while key_ready. KEY_SCHED_ZEROIZE_EN adds key_clear.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int RK_DEPTH = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      cfg_nk,
  input  logic [255:0]    key_in,
  input  logic            key_start,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic            key_clear,
`endif
  output logic            key_ready,
  output logic            key_valid,
  output logic            key_err,
  output logic [3:0]      nr,
  output logic [1:0]      ke_nk,
  output logic            ke_start,
  output logic            ke_w_valid,
  output logic [31:0]     ke_w,
  input  logic            ke_busy,
  input  logic            ke_rk_valid,
  input  logic            ke_rk_first,
  input  logic            ke_rk_last,
  input  logic [RK_W-1:0] ke_rk,
  input  logic            rk_rd_en,
  input  logic [3:0]      rk_rd_addr,
  output logic [RK_W-1:0] rk_rd_data
);

  localparam int IW = $clog2(TIMEOUT + 1);

  ks_state_t        state, state_n;
  logic [7:0][31:0] key_q;
  logic [1:0]       nk_q;
  logic [3:0]       nr_q;
  logic             key_valid_q;
  logic             key_err_q;
  logic [2:0]       wcnt;
  logic [4:0]       wr_ptr;
  logic [IW-1:0]    idle_cnt;

  logic             accept;
  logic             reject;
  logic             collecting;
  logic             abort;
  logic             rk_hit;
  logic [4:0]       wr_idx;
  logic             wr_fit;
  logic [4:0]       wr_cnt_n;
  logic             last_ok;

  logic             st_wr_en;
  logic [3:0]       st_wr_addr;
  logic [RK_W-1:0]  st_wr_data;

  // Progress is tracked from the round-key stream itself; busy is not needed for sequencing.
  logic             ke_busy_unused;
  assign ke_busy_unused = ke_busy;

`ifdef KEY_SCHED_ZEROIZE_EN
  logic             zero_pend;
  logic [3:0]       zptr;
  logic             zero_go;
  assign zero_go = zero_pend || key_clear;
`endif

  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign nr        = nr_q;
  assign ke_nk     = nk_q;

  // Round-key capture: a first flag restarts the schedule at index 0.
  assign rk_hit   = collecting && ke_rk_valid;
  assign wr_idx   = ke_rk_first ? 5'd0 : wr_ptr;
  assign wr_fit   = wr_idx <= {1'b0, nr_q};
  assign wr_cnt_n = ke_rk_first ? 5'd1 : ((wr_ptr == 5'd16) ? 5'd16 : wr_ptr + 5'd1);
  assign last_ok  = wr_cnt_n == ({1'b0, nr_q} + 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    reject     = 1'b0;
    collecting = 1'b0;
    abort      = 1'b0;
    key_ready  = 1'b0;
    ke_start   = 1'b0;
    ke_w_valid = 1'b0;
    ke_w       = '0;
    case (state)
      ST_IDLE: begin
`ifdef KEY_SCHED_ZEROIZE_EN
        key_ready = !zero_go;
        if (zero_go) begin
          state_n = ST_ZERO;
        end else
`else
        key_ready = 1'b1;
`endif
        if (key_start) begin
          if (cfg_nk == 2'b10) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = ST_START;
          end
        end
      end
      ST_START: begin
        ke_start = 1'b1;
        state_n  = ST_LOAD;
      end
      ST_LOAD: begin
        ke_w_valid = 1'b1;
        ke_w       = key_q[wcnt];
        collecting = 1'b1;
        if ({1'b0, wcnt} == nk_words(nk_q) - 4'd1) begin
          state_n = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        collecting = 1'b1;
        if (!ke_rk_valid && (idle_cnt == IW'(TIMEOUT - 1))) begin
          abort   = 1'b1;
          state_n = ST_IDLE;
        end
      end
`ifdef KEY_SCHED_ZEROIZE_EN
      ST_ZERO: begin
        if (zptr == 4'(RK_DEPTH - 1)) begin
          state_n = ST_IDLE;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
    if (rk_hit && ke_rk_last) begin
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      nk_q        <= 2'b00;
      nr_q        <= 4'd0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      wcnt        <= 3'd0;
      wr_ptr      <= 5'd0;
      idle_cnt    <= '0;
    end else begin
      if (accept) begin
        key_q       <= key_in;
        nk_q        <= cfg_nk;
        nr_q        <= nr_of(cfg_nk);
        key_valid_q <= 1'b0;
        key_err_q   <= 1'b0;
        wcnt        <= 3'd0;
        wr_ptr      <= 5'd0;
        idle_cnt    <= '0;
      end
      if (reject) begin
        key_err_q <= 1'b1;
      end
      if (state == ST_LOAD) begin
        wcnt <= wcnt + 3'd1;
      end
      if (rk_hit) begin
        wr_ptr   <= wr_cnt_n;
        idle_cnt <= '0;
        if (!wr_fit) begin
          key_err_q <= 1'b1;
        end
        if (ke_rk_last) begin
          if (last_ok) begin
            key_valid_q <= 1'b1;
          end else begin
            key_err_q <= 1'b1;
          end
        end
      end else if (state == ST_COLLECT) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (abort) begin
        key_err_q   <= 1'b1;
        key_valid_q <= 1'b0;
      end
`ifdef KEY_SCHED_ZEROIZE_EN
      if (state_n == ST_ZERO && state == ST_IDLE) begin
        key_valid_q <= 1'b0;
      end
`endif
    end
  end

`ifdef KEY_SCHED_ZEROIZE_EN
  // A wipe is owed after every reset and after any key_clear seen while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_pend <= 1'b1;
      zptr      <= 4'd0;
    end else begin
      if (state == ST_IDLE && zero_go) begin
        zero_pend <= 1'b0;
        zptr      <= 4'd0;
      end else if (state == ST_ZERO) begin
        zptr <= zptr + 4'd1;
      end else if (key_clear && state != ST_IDLE) begin
        zero_pend <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    st_wr_en   = rk_hit && wr_fit;
    st_wr_addr = wr_idx[3:0];
    st_wr_data = ke_rk;
`ifdef KEY_SCHED_ZEROIZE_EN
    if (state == ST_ZERO) begin
      st_wr_en   = 1'b1;
      st_wr_addr = zptr;
      st_wr_data = '0;
    end
`endif
  end

  key_sched_store #(
    .RK_DEPTH (RK_DEPTH)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (st_wr_en),
    .wr_addr  (st_wr_addr),
    .wr_data  (st_wr_data),
    .rd_en    (rk_rd_en),
    .rd_addr  (rk_rd_addr),
    .rd_max   (nr_q),
    .rd_allow (key_valid_q),
    .rd_data  (rk_rd_data)
  );

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: acts as the expansion engine and cipher-core reader, scoreboarding
// sent key words and read-port data against its own expected values.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   cfg_nk;
  logic [255:0] key_in;
  logic         key_start;
  logic         key_clear;
  logic         key_ready, key_valid, key_err;
  logic [3:0]   nr;
  logic [1:0]   ke_nk;
  logic         ke_start, ke_w_valid;
  logic [31:0]  ke_w;
  logic         ke_busy, ke_rk_valid, ke_rk_first, ke_rk_last;
  logic [127:0] ke_rk;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_q [$];
  logic [31:0]  word_q [$];
  logic         rd_pend;

  localparam logic [255:0] K128 = {128'hdeadbeef_cafef00d_01234567_89abcdef,
                                   128'h09cf4f3c_abf71588_28aed2a6_2b7e1516};
  localparam logic [255:0] K192 = {64'h0, 192'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7};
  localparam logic [255:0] K256 = 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;
  localparam logic [127:0] RK128 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
  localparam logic [127:0] RK192 = 128'h01002202_8ecc7204_448c773c_e98ba06f;
  localparam logic [127:0] RK256 = 128'h706c631e_046df344_e6188d0b_fe4890d1;

  always #5 clk = ~clk;

  key_sched_ctrl #(.TIMEOUT(64), .RK_DEPTH(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_nk      (cfg_nk),
    .key_in      (key_in),
    .key_start   (key_start),
`ifdef KEY_SCHED_ZEROIZE_EN
    .key_clear   (key_clear),
`endif
    .key_ready   (key_ready),
    .key_valid   (key_valid),
    .key_err     (key_err),
    .nr          (nr),
    .ke_nk       (ke_nk),
    .ke_start    (ke_start),
    .ke_w_valid  (ke_w_valid),
    .ke_w        (ke_w),
    .ke_busy     (ke_busy),
    .ke_rk_valid (ke_rk_valid),
    .ke_rk_first (ke_rk_first),
    .ke_rk_last  (ke_rk_last),
    .ke_rk       (ke_rk),
    .rk_rd_en    (rk_rd_en),
    .rk_rd_addr  (rk_rd_addr),
    .rk_rd_data  (rk_rd_data)
  );

  function automatic logic [127:0] rk_pat(input int i, input logic [1:0] nk);
    logic [3:0] ii;
    ii = i[3:0];
    return {24'ha5c3e1, ii, 2'b00, nk, 96'h0123456789abcdef0f1e2d3c};
  endfunction

  // Read-port scoreboard: data is due on the negedge after the edge that saw rk_rd_en.
  always @(posedge clk) rd_pend <= rk_rd_en;

  always @(negedge clk) begin
    logic [127:0] e;
    if (rd_pend === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got %h, no read outstanding", rk_rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rk_rd_data !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %h, want %h", rk_rd_data, e);
        end
      end
    end
  end

  task automatic rd_push(input logic [3:0] addr, input logic [127:0] e);
    @(negedge clk);
    rk_rd_en   = 1'b1;
    rk_rd_addr = addr;
    exp_q.push_back(e);
    @(negedge clk);
    rk_rd_en = 1'b0;
  endtask

  // Waits for key_ready, starts a load and checks the ke_start pulse and the word stream.
  task automatic load_key(input logic [1:0] nk, input logic [255:0] key);
    int nw, starts;
    logic [31:0] w;
    for (int g = 0; g < 50 && key_ready !== 1'b1; g++) @(negedge clk);
    n_cmp++;
    if (key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_wait: key_ready=%b, want 1", key_ready);
    end
    nw = (nk == 2'b00) ? 4 : (nk == 2'b01) ? 6 : 8;
    for (int i = 0; i < nw; i++) word_q.push_back(key[32*i +: 32]);
    @(negedge clk);
    key_start = 1'b1;
    cfg_nk    = nk;
    key_in    = key;
    @(negedge clk);
    key_start = 1'b0;
    starts = 0;
    for (int c = 0; c < nw + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (ke_start === 1'b1) starts++;
      if (ke_w_valid === 1'b1) begin
        n_cmp++;
        if (word_q.size() == 0) begin
          n_bad++;
          $display("FAIL ke_w_extra: got %h, no word expected", ke_w);
        end else begin
          w = word_q.pop_front();
          if (ke_w !== w) begin
            n_bad++;
            $display("FAIL ke_w: got %h, want %h", ke_w, w);
          end
        end
      end
    end
    n_cmp++;
    if (starts != 1 || word_q.size() != 0) begin
      n_bad++;
      $display("FAIL load_seq: ke_start cycles %0d want 1, words left %0d want 0", starts, word_q.size());
      word_q.delete();
    end
    n_cmp++;
    if (ke_nk !== nk) begin
      n_bad++;
      $display("FAIL ke_nk: got %b, want %b", ke_nk, nk);
    end
  endtask

  task automatic emit_rks(input int n, input logic [1:0] nk, input logic [127:0] last_rk, input logic with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ke_rk_valid = 1'b1;
      ke_rk_first = (i == 0);
      ke_rk_last  = with_last && (i == n - 1);
      ke_rk       = (with_last && i == n - 1) ? last_rk : rk_pat(i, nk);
    end
    @(negedge clk);
    ke_rk_valid = 1'b0;
    ke_rk_first = 1'b0;
    ke_rk_last  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
`ifdef KEY_SCHED_ZEROIZE_EN
    n_cmp++;
    if ({key_ready, key_valid, key_err, ke_start, ke_w_valid} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, want 00000", {key_ready, key_valid, key_err, ke_start, ke_w_valid});
    end
`else
    n_cmp++;
    if ({key_ready, key_valid, key_err, ke_start, ke_w_valid} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, want 10000", {key_ready, key_valid, key_err, ke_start, ke_w_valid});
    end
`endif
    n_cmp++;
    if ({nr, ke_nk} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_nr_nk: got nr=%0d nk=%b, want 0 00", nr, ke_nk);
    end
    n_cmp++;
    if (ke_w !== 32'd0 || rk_rd_data !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_data: got ke_w=%h rd=%h, want 0", ke_w, rk_rd_data);
    end
    rd_push(4'd0, 128'd0);
  endtask

  task automatic test_aes128();
    load_key(2'b00, K128);
    emit_rks(11, 2'b00, RK128, 1'b1);
    n_cmp++;
    if ({key_valid, key_err, key_ready, nr} !== {3'b101, 4'd10}) begin
      n_bad++;
      $display("FAIL aes128_done: got v=%b e=%b r=%b nr=%0d, want 1 0 1 10", key_valid, key_err, key_ready, nr);
    end
    rd_push(4'd0, rk_pat(0, 2'b00));
    rd_push(4'd11, 128'd0);
    rd_push(4'd10, RK128);
    @(negedge clk);
    n_cmp++;
    if (rk_rd_data !== RK128) begin
      n_bad++;
      $display("FAIL rd_hold: got %h, want %h", rk_rd_data, RK128);
    end
  endtask

  task automatic test_aes192();
    load_key(2'b01, K192);
    emit_rks(13, 2'b01, RK192, 1'b1);
    n_cmp++;
    if ({key_valid, key_err, nr} !== {2'b10, 4'd12}) begin
      n_bad++;
      $display("FAIL aes192_done: got v=%b e=%b nr=%0d, want 1 0 12", key_valid, key_err, nr);
    end
    rd_push(4'd12, RK192);
    rd_push(4'd13, 128'd0);
    rd_push(4'd3, rk_pat(3, 2'b01));
  endtask

  task automatic test_aes256();
    load_key(2'b11, K256);
    emit_rks(15, 2'b11, RK256, 1'b1);
    n_cmp++;
    if ({key_valid, key_err, nr} !== {2'b10, 4'd14}) begin
      n_bad++;
      $display("FAIL aes256_done: got v=%b e=%b nr=%0d, want 1 0 14", key_valid, key_err, nr);
    end
    rd_push(4'd14, RK256);
    rd_push(4'd15, 128'd0);
    rd_push(4'd13, rk_pat(13, 2'b11));
  endtask

  task automatic test_reserved();
    int starts;
    @(negedge clk);
    key_start = 1'b1;
    cfg_nk    = 2'b10;
    @(negedge clk);
    key_start = 1'b0;
    starts = 0;
    for (int c = 0; c < 4; c++) begin
      if (ke_start === 1'b1) starts++;
      @(negedge clk);
    end
    n_cmp++;
    if ({key_err, key_ready, key_valid, nr} !== {3'b111, 4'd14} || starts != 0) begin
      n_bad++;
      $display("FAIL reserved_nk: got e=%b r=%b v=%b nr=%0d starts=%0d, want 1 1 1 14 0",
               key_err, key_ready, key_valid, nr, starts);
    end
    load_key(2'b00, K128);
    n_cmp++;
    if ({key_err, key_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL err_clear: got e=%b v=%b, want 0 0", key_err, key_valid);
    end
    emit_rks(11, 2'b00, RK128, 1'b1);
    n_cmp++;
    if (key_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reload_valid: got %b, want 1", key_valid);
    end
  endtask

  task automatic test_timeout();
    logic rdy_mid;
    load_key(2'b00, K128);
    emit_rks(3, 2'b00, 128'd0, 1'b0);
    rdy_mid = 1'b0;
    for (int c = 0; c < 63; c++) begin
      @(negedge clk);
      key_start = (c == 10);
      cfg_nk    = 2'b01;
      if (c == 10) rdy_mid = key_ready;
    end
    n_cmp++;
    if ({key_err, key_valid, rdy_mid} !== 3'b000) begin
      n_bad++;
      $display("FAIL timeout_early: got e=%b v=%b ready=%b at idle 63, want 0 0 0", key_err, key_valid, rdy_mid);
    end
    @(negedge clk);
    n_cmp++;
    if ({key_err, key_valid, key_ready, nr} !== {3'b101, 4'd10}) begin
      n_bad++;
      $display("FAIL timeout_abort: got e=%b v=%b r=%b nr=%0d at idle 64, want 1 0 1 10",
               key_err, key_valid, key_ready, nr);
    end
  endtask

  task automatic test_overflow();
    load_key(2'b00, K128);
    emit_rks(12, 2'b00, RK128, 1'b1);
    n_cmp++;
    if ({key_err, key_valid, key_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL overflow: got e=%b v=%b r=%b, want 1 0 1", key_err, key_valid, key_ready);
    end
    rd_push(4'd10, 128'd0);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    key_start = 1'b1;
    cfg_nk    = 2'b11;
    key_in    = K256;
    @(negedge clk);
    key_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
`ifdef KEY_SCHED_ZEROIZE_EN
    n_cmp++;
    if ({key_ready, key_valid, key_err, ke_start, ke_w_valid} !== 5'b00000) begin
      n_bad++;
      $display("FAIL midrst_flags: got %b, want 00000", {key_ready, key_valid, key_err, ke_start, ke_w_valid});
    end
`else
    n_cmp++;
    if ({key_ready, key_valid, key_err, ke_start, ke_w_valid} !== 5'b10000) begin
      n_bad++;
      $display("FAIL midrst_flags: got %b, want 10000", {key_ready, key_valid, key_err, ke_start, ke_w_valid});
    end
`endif
    n_cmp++;
    if ({nr, ke_nk} !== 6'd0 || ke_w !== 32'd0 || rk_rd_data !== 128'd0) begin
      n_bad++;
      $display("FAIL midrst_data: got nr=%0d nk=%b w=%h rd=%h, want 0", nr, ke_nk, ke_w, rk_rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    load_key(2'b00, K128);
    emit_rks(11, 2'b00, RK128, 1'b1);
    rd_push(4'd10, RK128);
  endtask

`ifdef KEY_SCHED_ZEROIZE_EN
  task automatic test_zeroize();
    int zc;
    @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    zc = 0;
    for (int c = 0; c < 40 && key_ready !== 1'b1; c++) begin
      if (key_valid !== 1'b0) zc = 100;
      zc++;
      @(negedge clk);
    end
    n_cmp++;
    if (zc != 15) begin
      n_bad++;
      $display("FAIL zero_cycles: got %0d, want 15", zc);
    end
    rd_push(4'd0, 128'd0);
  endtask
`endif

  initial begin
    rst         = 1'b1;
    cfg_nk      = 2'b00;
    key_in      = '0;
    key_start   = 1'b0;
    key_clear   = 1'b0;
    ke_busy     = 1'b0;
    ke_rk_valid = 1'b0;
    ke_rk_first = 1'b0;
    ke_rk_last  = 1'b0;
    ke_rk       = '0;
    rk_rd_en    = 1'b0;
    rk_rd_addr  = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_reserved();
    test_timeout();
    test_overflow();
    test_reset_mid_load();
`ifdef KEY_SCHED_ZEROIZE_EN
    test_zeroize();
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rd_outstanding: got %0d reads unanswered, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
